// File: rtl/uart_word_tx_if.sv
// Store-path bus of the word UART: CPU write strobe and data, overflow clear, FIFO status.
// wr_en is a single-cycle strobe with no back-pressure: the word is taken on that edge when full=0, dropped (setting ovf) otherwise.
interface uart_word_tx_if #(
  parameter int FIFO_DEPTH = 4
) ();
  logic                          wr_en;
  logic [31:0]                   wr_data;
  logic                          clr_ovf;
  logic                          full;
  logic                          ovf;
  logic                          busy;
  logic [$clog2(FIFO_DEPTH):0]   fifo_cnt;

  modport master (
    output wr_en, wr_data, clr_ovf,
    input  full, ovf, busy, fifo_cnt
  );

  modport slave (
    input  wr_en, wr_data, clr_ovf,
    output full, ovf, busy, fifo_cnt
  );
endinterface

// File: rtl/uart_word_tx.sv
// 8N1 UART transmitter for 32-bit words: a small word FIFO feeds a START/DATA/STOP framer that
// sends each word as four bytes, least significant byte first.
module uart_word_tx #(
  parameter int BAUD_DIV   = 868,
  parameter int FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rstn,
  uart_word_tx_if.slave   bus,
  output logic            tx,
  output logic [1:0]      state_dbg
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(BAUD_DIV);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d, bit_nx;
  logic [1:0]      byte_q, byte_d;
  logic [31:0]     word_q;
  logic            tx_q, tx_d;
  logic [31:0]     mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   cnt_q;
  logic            ovf_q, busy_q;
  logic            full, push, drop, pop, baud_done;

  // full comes from the registered count, so a same-cycle pop never frees room for a write.
  assign full      = (cnt_q == CNT_FULL);
  assign push      = bus.wr_en & ~full;
  assign drop      = bus.wr_en & full;
  assign baud_done = (baud_q == BAUD_LAST);
  assign bit_nx    = bit_q + 3'd1;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= bus.wr_data;
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + BW'(1);
    bit_d   = bit_q;
    byte_d  = byte_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        tx_d   = 1'b1;
        if (cnt_q != '0) begin
          pop     = 1'b1;
          state_d = START;
          byte_d  = 2'd0;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (baud_done) begin
          baud_d  = '0;
          state_d = DATA;
          bit_d   = 3'd0;
          tx_d    = word_q[{byte_q, 3'd0}];
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_nx;
            tx_d  = word_q[{byte_q, bit_nx}];
          end
        end
      end
      STOP: begin
        if (baud_done) begin
          baud_d = '0;
          if (byte_q != 2'd3) begin
            byte_d  = byte_q + 2'd1;
            state_d = START;
            tx_d    = 1'b0;
          end else if (cnt_q != '0) begin
            // Next word starts straight after this stop bit, no idle gap.
            pop     = 1'b1;
            byte_d  = 2'd0;
            state_d = START;
            tx_d    = 1'b0;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      byte_q   <= '0;
      word_q   <= '0;
      tx_q     <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      tx_q    <= tx_d;
      if (pop)  word_q   <= mem[rd_ptr_q];
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      if (push && !pop)      cnt_q <= cnt_q + CW'(1);
      else if (pop && !push) cnt_q <= cnt_q - CW'(1);
      if (drop)             ovf_q <= 1'b1;
      else if (bus.clr_ovf) ovf_q <= 1'b0;
      busy_q <= (state_q != IDLE) | (cnt_q != '0);
    end
  end

  assign bus.full     = full;
  assign bus.ovf      = ovf_q;
  assign bus.busy     = busy_q;
  assign bus.fifo_cnt = cnt_q;
  assign tx           = tx_q;
  assign state_dbg    = state_q;
endmodule

// File: tb/tb_uart_word_tx.sv
// Directed bench for uart_word_tx: a line decoder feeds an expected-byte scoreboard, plus
// cycle-exact checks of framing, overflow, reset abort and simultaneous push/pop.
module tb_uart_word_tx;
  localparam int BAUD_DIV   = 4;
  localparam int FIFO_DEPTH = 4;
  localparam logic [1:0] S_IDLE = 2'd0, S_START = 2'd1, S_DATA = 2'd2, S_STOP = 2'd3;

  logic       clk, rstn, tx;
  logic [1:0] state_dbg;

  uart_word_tx_if #(.FIFO_DEPTH(FIFO_DEPTH)) bus ();

  uart_word_tx #(.BAUD_DIV(BAUD_DIV), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .bus       (bus.slave),
    .tx        (tx),
    .state_dbg (state_dbg)
  );

  int         checks = 0;
  int         errors = 0;
  int         cyc    = 0;
  logic [7:0] exp_q[$];
  int         start_q[$];
  logic       rx_busy = 1'b0;
  int         rx_cnt  = 0;
  logic [7:0] rx_byte = '0;

  typedef struct {
    logic [31:0] word;
    logic [7:0]  b0, b1, b2, b3;
  } vec_t;
  vec_t vecs[5];

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc++;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Line decoder: start seen at count 0, bits sampled mid-bit (every 4 cycles from 2).
  always @(negedge clk) begin
    if (!rstn) begin
      rx_busy = 1'b0;
      rx_cnt  = 0;
    end else if (!rx_busy) begin
      if (tx == 1'b0) begin
        rx_busy = 1'b1;
        rx_cnt  = 1;
        rx_byte = '0;
        start_q.push_back(cyc);
      end
    end else begin
      if (rx_cnt == 2) check("start_bit", tx, 1'b0);
      else if (rx_cnt >= 6 && rx_cnt <= 34 && (rx_cnt % 4) == 2) rx_byte = {tx, rx_byte[7:1]};
      else if (rx_cnt == 38) begin
        check("stop_bit", tx, 1'b1);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got %02h, expected no frame", rx_byte);
        end else check("rx_byte", rx_byte, exp_q.pop_front());
        rx_busy = 1'b0;
      end
      rx_cnt++;
    end
  end

  // driver tasks
  task automatic push_exp(input logic [31:0] w);
    for (int k = 0; k < 4; k++) exp_q.push_back(w[8*k +: 8]);
  endtask

  task automatic write_word(input logic [31:0] w);
    @(posedge clk); #1;
    bus.wr_en   = 1'b1;
    bus.wr_data = w;
    @(posedge clk); #1;
    bus.wr_en   = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    repeat (2) @(negedge clk);
    while ((bus.busy !== 1'b0 || rx_busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.busy !== 1'b0 || rx_busy) begin
      errors++;
      $display("FAIL wait_idle: busy=%0b after %0d cycles, expected 0", bus.busy, budget);
    end
  endtask

  logic [7:0]  s2_bytes[4];
  logic [7:0]  tmp_byte;
  logic        exp_bit;
  logic [31:0] ow[6];
  int          fr, pos;

  initial begin
    vecs[0] = '{32'h12345678, 8'h78, 8'h56, 8'h34, 8'h12};
    vecs[1] = '{32'hA5A5A5A5, 8'hA5, 8'hA5, 8'hA5, 8'hA5};
    vecs[2] = '{32'h000000FF, 8'hFF, 8'h00, 8'h00, 8'h00};
    vecs[3] = '{32'hDEADBEEF, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    vecs[4] = '{32'h80000001, 8'h01, 8'h00, 8'h00, 8'h80};
    s2_bytes = '{8'h78, 8'h56, 8'h34, 8'h12};
    ow = '{32'h01C33C10, 32'h02C33C11, 32'h03C33C12, 32'h04C33C13, 32'h05C33C14, 32'hDEADDEAD};

    bus.wr_en = 1'b0; bus.wr_data = '0; bus.clr_ovf = 1'b0;
    rstn = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("rst_tx", tx, 1'b1);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_cnt", bus.fifo_cnt, 0);
    check("rst_ovf", bus.ovf, 1'b0);
    check("rst_full", bus.full, 1'b0);
    check("rst_state", state_dbg, S_IDLE);
    @(negedge clk); rstn = 1'b1;

    // 1. idle after reset
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_tx", tx, 1'b1);
      check("idle_busy", bus.busy, 1'b0);
      check("idle_cnt", bus.fifo_cnt, 0);
      check("idle_ovf", bus.ovf, 1'b0);
    end

    // 2. single word, cycle-exact waveform
    push_exp(32'h12345678);
    write_word(32'h12345678);
    @(negedge clk);
    check("s2_pre_tx", tx, 1'b1);
    check("s2_pre_cnt", bus.fifo_cnt, 1);
    for (int i = 0; i < 160; i++) begin
      @(negedge clk);
      fr  = i / 40;
      pos = (i % 40) / 4;
      if (pos == 0) exp_bit = 1'b0;
      else if (pos == 9) exp_bit = 1'b1;
      else begin
        tmp_byte = s2_bytes[fr];
        exp_bit  = tmp_byte[pos-1];
      end
      check("s2_line", tx, exp_bit);
    end
    @(negedge clk);
    check("s2_end_tx", tx, 1'b1);
    check("s2_end_busy_lag", bus.busy, 1'b1);
    @(negedge clk);
    check("s2_end_busy", bus.busy, 1'b0);
    check("s2_end_state", state_dbg, S_IDLE);
    wait_idle(50);
    check("s2_scoreboard", exp_q.size(), 0);

    // table of words with hand-written byte order
    for (int v = 0; v < 5; v++) begin
      exp_q.push_back(vecs[v].b0);
      exp_q.push_back(vecs[v].b1);
      exp_q.push_back(vecs[v].b2);
      exp_q.push_back(vecs[v].b3);
      write_word(vecs[v].word);
      wait_idle(400);
      check("vec_scoreboard", exp_q.size(), 0);
    end

    // 3. back-to-back words
    start_q.delete();
    push_exp(32'hA5A5A5A5);
    push_exp(32'h000000FF);
    @(posedge clk); #1; bus.wr_en = 1'b1; bus.wr_data = 32'hA5A5A5A5;
    @(posedge clk); #1; bus.wr_data = 32'h000000FF;
    @(posedge clk); #1; bus.wr_en = 1'b0;
    wait_idle(800);
    check("b2b_frames", start_q.size(), 8);
    for (int i = 1; i < start_q.size(); i++) check("b2b_gap", start_q[i] - start_q[i-1], 40);
    check("b2b_scoreboard", exp_q.size(), 0);

    // 4. overflow
    for (int k = 0; k < 5; k++) push_exp(ow[k]);
    @(posedge clk); #1; bus.wr_en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      bus.wr_data = ow[k];
      @(posedge clk); #1;
    end
    bus.wr_en = 1'b0;
    check("ovf_cnt", bus.fifo_cnt, 4);
    check("ovf_full", bus.full, 1'b1);
    check("ovf_set", bus.ovf, 1'b1);
    @(negedge clk);
    check("ovf_sticky", bus.ovf, 1'b1);
    @(posedge clk); #1; bus.clr_ovf = 1'b1;
    @(posedge clk); #1; bus.clr_ovf = 1'b0;
    check("ovf_clr", bus.ovf, 1'b0);
    check("ovf_still_full", bus.full, 1'b1);
    bus.wr_en = 1'b1; bus.wr_data = 32'hBAD0BAD0; bus.clr_ovf = 1'b1;
    @(posedge clk); #1; bus.wr_en = 1'b0; bus.clr_ovf = 1'b0;
    check("ovf_drop_wins", bus.ovf, 1'b1);
    check("ovf_drop_cnt", bus.fifo_cnt, 4);
    bus.clr_ovf = 1'b1;
    @(posedge clk); #1; bus.clr_ovf = 1'b0;
    check("ovf_clr2", bus.ovf, 1'b0);
    wait_idle(1200);
    check("ovf_scoreboard", exp_q.size(), 0);

    // 5. reset during byte 1, data bit 3
    exp_q.push_back(8'h0D);
    @(posedge clk); #1; bus.wr_en = 1'b1; bus.wr_data = 32'hCAFEF00D;
    @(posedge clk); #1; bus.wr_data = 32'h0BADBEEF;
    @(posedge clk); #1; bus.wr_en = 1'b0;
    repeat (58) @(posedge clk); #1;
    check("mid_state", state_dbg, S_DATA);
    rstn = 1'b0;
    #1;
    check("mid_rst_tx", tx, 1'b1);
    check("mid_rst_cnt", bus.fifo_cnt, 0);
    check("mid_rst_busy", bus.busy, 1'b0);
    check("mid_rst_state", state_dbg, S_IDLE);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      check("post_rst_tx", tx, 1'b1);
    end
    check("post_rst_busy", bus.busy, 1'b0);
    check("post_rst_scoreboard", exp_q.size(), 0);
    push_exp(32'h600DCAFE);
    write_word(32'h600DCAFE);
    wait_idle(400);
    check("post_rst_word", exp_q.size(), 0);

    // 6. push on the STOP-to-START pop edge with two words queued
    push_exp(32'h11223344);
    push_exp(32'h55667788);
    push_exp(32'h99AABBCC);
    push_exp(32'hDDEEFF00);
    @(posedge clk); #1; bus.wr_en = 1'b1; bus.wr_data = 32'h11223344;
    @(posedge clk); #1; bus.wr_data = 32'h55667788;
    @(posedge clk); #1; bus.wr_data = 32'h99AABBCC;
    @(posedge clk); #1; bus.wr_en = 1'b0;
    repeat (158) @(posedge clk); #1;
    check("pp_pre_cnt", bus.fifo_cnt, 2);
    check("pp_pre_state", state_dbg, S_STOP);
    bus.wr_en = 1'b1; bus.wr_data = 32'hDDEEFF00;
    @(posedge clk); #1; bus.wr_en = 1'b0;
    check("pp_cnt", bus.fifo_cnt, 2);
    check("pp_state", state_dbg, S_START);
    check("pp_tx", tx, 1'b0);
    wait_idle(1000);
    check("pp_scoreboard", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
